loop_sequencer: RTL
===================

// Module: loop_sequencer
// PURPOSE
//  Control sequencer that resolves '[' / ']' jumps for core: scans pmem for the matching bracket and returns the branch target PC.
//  Sits between core and rom_pmem. While busy it owns pmem_addr; core holds its pc until done.
//  Depth-counted scan, one pmem word per cycle.
// PARAMETERS
//  ADDR_W    16     pmem address width (= tape/pmem address width)
//  DEPTH_W   16     nesting depth counter width
//  PROG_LEN  65536  number of valid pmem words; addresses >= PROG_LEN are out of program
//  STACK_N   16     loop-stack entries (used only with LOOP_STACK_EN)
// PORTS
//  clock        in   1       system clock
//  reset_n      in   1       asynchronous active-low reset
//  start_valid  in   1       core requests jump resolution; sampled only in IDLE
//  start_dir    in   1       0 = forward (at '[', cell==0), 1 = backward (at ']', cell!=0)
//  start_pc     in   ADDR_W  pc of the bracket being executed
//  pmem_addr    out  ADDR_W  scan address to rom_pmem (combinational read)
//  pmem_data    in   3       opcode at pmem_addr, same cycle
//  busy         out  1       high from cycle after accept until done cycle inclusive
//  done         out  1       1-cycle pulse: target_pc/error valid
//  target_pc    out  ADDR_W  pc core resumes at; held until next done
//  error        out  1       with done: unmatched bracket or depth overflow
//  loop_push    in   1       core entered loop body ('[' with cell!=0)
//  loop_pop     in   1       core left loop (']' with cell==0)
// BEHAVIOUR
//  Reset: state IDLE; busy, done, error = 0; target_pc, pmem_addr, depth = 0; stack empty.
//  Reset mid-scan aborts immediately to IDLE; no done is issued.
//  IDLE: start_valid=1 -> SCAN; depth <= 1; addr <= start_pc+1 (fwd) or start_pc-1 (bwd).
//  start_valid while busy is ignored; core must not assert it.
//  SCAN, once per cycle at addr:
//    fwd: '[' -> depth+1; ']' -> depth-1.
//    bwd: ']' -> depth+1; '[' -> depth-1.
//    Other opcodes leave depth unchanged.
//    When depth reaches 0: target_pc <= addr+1, done pulse, return to IDLE.
//    Otherwise addr steps +1 (fwd) or -1 (bwd).
//  Latency: done asserts |match_addr - start_pc| cycles after the accept cycle.
//    Adjacent match ("[]") = 1 cycle.
//  Unmatched:
//    fwd with addr = PROG_LEN-1 and no match, or bwd with addr = 0 and no match,
//      -> done + error, target_pc <= start_pc.
//    Addresses never wrap.
//    depth increment at max value -> done + error.
//  IDLE drives pmem_addr = 0. DONE is not a separate state.
//  States: IDLE, SCAN (+ HIT when LOOP_STACK_EN).
// CONFIGURATION
//  LOOP_STACK_EN defined:
//    LIFO of STACK_N '[' PCs. loop_push stores start_pc-of-'[' (sampled on start_pc); loop_pop removes top.
//    bwd request with stack valid -> HIT: done next cycle, target_pc = top+1, no pmem access.
//    Stack is not popped on HIT.
//    Push when full: dropped, ovf_cnt++. Pop with ovf_cnt>0 decrements ovf_cnt instead of the stack.
//    Stack valid = non-empty && ovf_cnt==0.
//    Pop when empty is ignored. push+pop in the same cycle: pop is applied first, then push.
//    fwd requests always scan.
//  LOOP_STACK_EN undefined:
//    loop_push/loop_pop ports remain and are ignored; all jumps scan; no stack storage is synthesized.
// STRUCTURE
//  Package tdc_pkg:
//    opcode_t enum: OP_INC=0, OP_DEC=1, OP_RIGHT=2, OP_LEFT=3, OP_OUT=4, OP_IN=5, OP_OPEN=6, OP_CLOSE=7.
//    ADDR_W constant.
//    seq_state_t enum.
//  Sub-module loop_stack: LIFO with push/pop/top/valid/ovf_cnt; instantiated only under LOOP_STACK_EN.
// TESTING
//  1. Program "[+]" at 0, fwd start_pc=0 -> busy for 2 cycles, done, target_pc=3, error=0.
//  2. Program "+[[-]>]" at 0, bwd start_pc=6 -> scans 5,4,3,2,1; done 5 cycles after accept, target_pc=2.
//  3. Program "[++" with PROG_LEN=3, fwd start_pc=0 -> done+error at addr 2, target_pc=0.
//  4. Assert reset_n low in second SCAN cycle -> busy=0, done never pulses, pmem_addr=0; next start works.
//  5. LOOP_STACK_EN: push at pc 1, bwd start_pc=6 -> done in 1 cycle, target_pc=2, pmem untouched.
//     Then pop, bwd again -> falls back to scan.
//  6. LOOP_STACK_EN, STACK_N=2: 3 pushes (pc 0, 1, 2), 1 pop -> stack valid; bwd -> target_pc=2.

Source files
------------

// File: rtl/tdc_pkg.sv
// Shared types for the loop sequencer slice: opcodes, address width, FSM states.
// The HIT state exists only when LOOP_STACK_EN is defined.
package tdc_pkg;

    localparam int ADDR_W = 16;

    typedef enum logic [2:0] {
        OP_INC   = 3'd0,
        OP_DEC   = 3'd1,
        OP_RIGHT = 3'd2,
        OP_LEFT  = 3'd3,
        OP_OUT   = 3'd4,
        OP_IN    = 3'd5,
        OP_OPEN  = 3'd6,
        OP_CLOSE = 3'd7
    } opcode_t;

`ifdef LOOP_STACK_EN
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_HIT
    } seq_state_t;
`else
    typedef enum logic [0:0] {
        ST_IDLE,
        ST_SCAN
    } seq_state_t;
`endif

endpackage

// File: rtl/loop_stack.sv
// LIFO of '[' PCs with overflow counter; top is valid when non-empty and no overflow.
// Ports: clock, reset_n, push/pop/push_pc in; top, valid, ovf_cnt out. Built only with LOOP_STACK_EN.
`ifdef LOOP_STACK_EN
module loop_stack #(
    parameter int ADDR_W  = 16,
    parameter int STACK_N = 16,
    parameter int CNT_W   = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_pc,
    output logic [ADDR_W-1:0] top,
    output logic              valid,
    output logic [CNT_W-1:0]  ovf_cnt
);
    localparam int PW = $clog2(STACK_N + 1);
    localparam int IW = (STACK_N > 1) ? $clog2(STACK_N) : 1;
    localparam logic [PW-1:0] FULL = PW'(STACK_N);
    localparam logic [PW-1:0] P_ONE = PW'(1);
    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

    logic [ADDR_W-1:0] mem [STACK_N];
    logic [PW-1:0]     cnt_q, cnt_d, cnt_mid;
    logic [CNT_W-1:0]  ovf_q, ovf_d;
    logic              wr_en;
    logic [IW-1:0]     wr_idx;

    // Pop resolves first so a same-cycle push sees the popped depth.
    always_comb begin
        cnt_mid = cnt_q;
        ovf_d   = ovf_q;
        wr_en   = 1'b0;
        wr_idx  = '0;
        if (pop) begin
            if (ovf_q != '0)
                ovf_d = ovf_q - C_ONE;
            else if (cnt_q != '0)
                cnt_mid = cnt_q - P_ONE;
        end
        cnt_d = cnt_mid;
        if (push) begin
            if (cnt_mid == FULL) begin
                if (ovf_d != '1)
                    ovf_d = ovf_d + C_ONE;
            end else begin
                wr_en  = 1'b1;
                wr_idx = IW'(cnt_mid);
                cnt_d  = cnt_mid + P_ONE;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            ovf_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en)
            mem[wr_idx] <= push_pc;
    end

    assign top     = mem[IW'(cnt_q - P_ONE)];
    assign valid   = (cnt_q != '0) && (ovf_q == '0);
    assign ovf_cnt = ovf_q;

endmodule
`endif

// File: rtl/loop_sequencer.sv
// Resolves '[' / ']' jumps by depth-counted pmem scan; done/error/target_pc report the result.
// Ports: clock, reset_n, start_*, pmem_addr/pmem_data, busy, done, target_pc, error, loop_push/pop. Macro: LOOP_STACK_EN.
module loop_sequencer #(
    parameter int ADDR_W   = tdc_pkg::ADDR_W,
    parameter int DEPTH_W  = 16,
    parameter int PROG_LEN = 65536,
    parameter int STACK_N  = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start_valid,
    input  logic              start_dir,
    input  logic [ADDR_W-1:0] start_pc,
    output logic [ADDR_W-1:0] pmem_addr,
    input  logic [2:0]        pmem_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] target_pc,
    output logic              error,
    input  logic              loop_push,
    input  logic              loop_pop
);
    import tdc_pkg::*;

    localparam logic [ADDR_W-1:0]  LAST  = ADDR_W'(PROG_LEN - 1);
    localparam logic [ADDR_W-1:0]  A_ONE = ADDR_W'(1);
    localparam logic [DEPTH_W-1:0] D_ONE = DEPTH_W'(1);

    seq_state_t         state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic [ADDR_W-1:0]  tgt_q, tgt_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               dir_q, dir_d;
    logic               edge_q, edge_d;
    opcode_t            op;
    logic               inc, dec, at_end;

`ifdef LOOP_STACK_EN
    logic               stk_valid;
    logic [ADDR_W-1:0]  stk_top;
    logic [DEPTH_W-1:0] unused_ovf;

    loop_stack #(
        .ADDR_W  (ADDR_W),
        .STACK_N (STACK_N),
        .CNT_W   (DEPTH_W)
    ) u_stack (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (loop_push),
        .pop     (loop_pop),
        .push_pc (start_pc),
        .top     (stk_top),
        .valid   (stk_valid),
        .ovf_cnt (unused_ovf)
    );
`else
    logic unused_ok;
    assign unused_ok = &{1'b0, loop_push, loop_pop};
`endif

    assign op     = opcode_t'(pmem_data);
    assign inc    = dir_q ? (op == OP_CLOSE) : (op == OP_OPEN);
    assign dec    = dir_q ? (op == OP_OPEN) : (op == OP_CLOSE);
    assign at_end = dir_q ? (addr_q == '0) : (addr_q == LAST);

    assign busy      = (state_q != ST_IDLE);
    assign pmem_addr = (state_q == ST_SCAN) ? addr_q : '0;

    // done/error are asserted in the resolving cycle; target_pc
    // bypasses the register then so it is valid alongside done.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        base_d    = base_q;
        tgt_d     = tgt_q;
        depth_d   = depth_q;
        dir_d     = dir_q;
        edge_d    = edge_q;
        done      = 1'b0;
        error     = 1'b0;
        target_pc = tgt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_valid) begin
                    base_d = start_pc;
                    dir_d  = start_dir;
`ifdef LOOP_STACK_EN
                    if (start_dir && stk_valid)
                        state_d = ST_HIT;
                    else
`endif
                    begin
                        state_d = ST_SCAN;
                        depth_d = D_ONE;
                        addr_d  = start_dir ? start_pc - A_ONE
                                            : start_pc + A_ONE;
                        // first scan address would leave the program
                        edge_d  = start_dir ? (start_pc == '0)
                                            : (start_pc >= LAST);
                    end
                end
            end
            ST_SCAN: begin
                if (!edge_q && dec && depth_q == D_ONE) begin
                    done      = 1'b1;
                    tgt_d     = addr_q + A_ONE;
                    target_pc = tgt_d;
                    state_d   = ST_IDLE;
                end else if (edge_q || at_end || (inc && depth_q == '1)) begin
                    done      = 1'b1;
                    error     = 1'b1;
                    tgt_d     = base_q;
                    target_pc = base_q;
                    state_d   = ST_IDLE;
                end else begin
                    if (inc)
                        depth_d = depth_q + D_ONE;
                    else if (dec)
                        depth_d = depth_q - D_ONE;
                    addr_d = dir_q ? addr_q - A_ONE : addr_q + A_ONE;
                end
            end
`ifdef LOOP_STACK_EN
            ST_HIT: begin
                done      = 1'b1;
                tgt_d     = stk_top + A_ONE;
                target_pc = tgt_d;
                state_d   = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            base_q  <= '0;
            tgt_q   <= '0;
            depth_q <= '0;
            dir_q   <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            base_q  <= base_d;
            tgt_q   <= tgt_d;
            depth_q <= depth_d;
            dir_q   <= dir_d;
            edge_q  <= edge_d;
        end
    end

endmodule
